// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier operand-issue stage.
package mult_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 16;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        ISSUE     = ST_ISSUE,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } state_t;

    // Operand pair as stored in the FIFO: a in the upper byte, b in the lower.
    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/mult_issue_if.sv
// Start/busy handshake bundle between the issue stage and the shift-add multiplier.
interface mul_if;
    import mult_pkg::*;

    logic             start;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic             busy;
    logic [RES_W-1:0] y;

    modport master (output start, output a, output b, input busy, input y);
    modport slave  (input start, input a, input b, output busy, output y);

endinterface

// File: rtl/mult_issue_op_fifo.sv
// Synchronous operand-pair FIFO; the head is read combinationally from storage.
module op_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  op_pair_t  wdata_i,
    output op_pair_t  rdata_o,
    output logic      full_o,
    output logic      empty_o,
    output logic [AW:0] level_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    op_pair_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mult_issue.sv
// Operand-issue and result-capture stage around the 8x8 sequential multiplier.
//   state     | meaning
//   IDLE      | waiting for a queued pair and a free output register
//   ISSUE     | start pulse high, operands presented
//   WAIT_BUSY | waiting for busy to rise, bounded by BUSY_TO
//   WAIT_DONE | multiplier running; capture product when busy falls
module mult_issue
    import mult_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int BUSY_TO = 4,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  in_a_bi,
    input  logic [OP_W-1:0]  in_b_bi,
    output logic             mul_start_o,
    output logic [OP_W-1:0]  mul_a_bo,
    output logic [OP_W-1:0]  mul_b_bo,
    input  logic             mul_busy_i,
    input  logic [RES_W-1:0] mul_y_bi,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [RES_W-1:0] out_y_bo,
    output logic [LW-1:0]    level_o,
    output logic             err_o
);

    localparam int TW = $clog2(BUSY_TO + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             start_q, start_d;
    logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
    logic             valid_q, valid_d;
    logic [RES_W-1:0] y_q, y_d;
    logic             err_q, err_d;

    op_pair_t head;
    op_pair_t wdata;
    logic     fifo_full, fifo_empty, fifo_pop;

    assign wdata = '{a: in_a_bi, b: in_b_bi};

    op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (in_valid_i),
        .pop_i   (fifo_pop),
        .wdata_i (wdata),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign in_ready_o  = !fifo_full;
    assign mul_start_o = start_q;
    assign mul_a_bo    = a_q;
    assign mul_b_bo    = b_q;
    assign out_valid_o = valid_q;
    assign out_y_bo    = y_q;
    assign err_o       = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        y_d      = y_q;
        valid_d  = valid_q && !out_ready_i;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                // Only issue when the output register is free or freeing this edge.
                if (!fifo_empty && (!valid_q || out_ready_i)) begin
                    fifo_pop = 1'b1;
                    a_d      = head.a;
                    b_d      = head.b;
                    start_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (mul_busy_i) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!mul_busy_i) begin
                    y_d     = mul_y_bi;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mult_issue.sv
// Directed bench for mult_issue with a behavioural shift-add multiplier and a product scoreboard.
module tb_mult_issue;
    import mult_pkg::*;

    localparam int DEPTH   = 4;
    localparam int BUSY_TO = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid, in_ready;
    logic [7:0]  in_a, in_b;
    logic        out_valid, out_ready;
    logic [15:0] out_y;
    logic [2:0]  level;
    logic        err;

    mul_if m ();

    always #5 clk = ~clk;

    mult_issue #(.DEPTH(DEPTH), .BUSY_TO(BUSY_TO)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_bi     (in_a),
        .in_b_bi     (in_b),
        .mul_start_o (m.start),
        .mul_a_bo    (m.a),
        .mul_b_bo    (m.b),
        .mul_busy_i  (m.busy),
        .mul_y_bi    (m.y),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_y_bo    (out_y),
        .level_o     (level),
        .err_o       (err)
    );

    // Behavioural multiplier: busy for 9 cycles after a sampled start; result valid once idle.
    logic       dead;
    logic [3:0] mcnt;
    logic [7:0] pa, pb;
    always @(posedge clk) begin
        if (!rstn) begin
            m.busy <= 1'b0;
            m.y    <= 16'h0;
            mcnt   <= 4'd0;
        end else if (m.busy) begin
            if (mcnt == 4'd8) begin
                m.busy <= 1'b0;
                m.y    <= 16'(pa) * 16'(pb);
            end
            mcnt <= mcnt + 4'd1;
        end else if (m.start && !dead) begin
            m.busy <= 1'b1;
            m.y    <= 16'hdead;
            mcnt   <= 4'd0;
            pa     <= m.a;
            pb     <= m.b;
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          n_out = 0;
    logic [15:0] sb [$];
    logic        prev_start = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push on accepted input, pop/compare on accepted output.
    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) chk("out_y", 32'(out_y), 32'(sb.pop_front()));
                n_out++;
            end
            if (in_valid && in_ready) sb.push_back(16'(in_a) * 16'(in_b));
            if (m.start) begin
                chk("start_not_busy", 32'(m.busy), 32'd0);
                chk("start_one_cycle", 32'(prev_start), 32'd0);
            end
        end
        prev_start = m.start;
    end

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_nout(input int target, input string tag);
        int t = 0;
        while (n_out < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(n_out), 32'(target));
    endtask

    task automatic wait_start(input string tag);
        int t = 0;
        @(negedge clk);
        while (!m.start && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(m.start), 32'd1);
    endtask

    logic [7:0] ta [6] = '{8'd255, 8'd0, 8'd1, 8'd16, 8'd3, 8'd200};
    logic [7:0] tb [6] = '{8'd255, 8'd255, 8'd1, 8'd16, 8'd7, 8'd2};

    initial begin
        int start_cyc, val_cyc, nstart, cyc, idx;
        logic [7:0]  sa, sbv;
        logic [15:0] yv, y0;
        logic [2:0]  lvl2;
        logic        acc, stable;
        int          n_before;

        in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
        out_ready = 1'b1; dead = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_start", 32'(m.start), 32'd0);
        chk("rst_mul_ab", 32'({m.a, m.b}), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1; rstn = 1'b1;

        // 1: single pair reference latency
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'd12; in_b = 8'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        start_cyc = -1; val_cyc = -1; nstart = 0;
        sa = 8'd0; sbv = 8'd0; yv = 16'd0; lvl2 = 3'd7;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (m.start) begin
                nstart++;
                if (start_cyc < 0) begin start_cyc = c; sa = m.a; sbv = m.b; end
            end
            if (out_valid && val_cyc < 0) begin val_cyc = c; yv = out_y; end
            if (c == 2) lvl2 = level;
        end
        chk("t1_start_cycle", 32'(start_cyc), 32'd2);
        chk("t1_start_count", 32'(nstart), 32'd1);
        chk("t1_mul_a", 32'(sa), 32'd12);
        chk("t1_mul_b", 32'(sbv), 32'd13);
        chk("t1_valid_cycle", 32'(val_cyc), 32'd13);
        chk("t1_out_y", 32'(yv), 32'd156);
        chk("t1_level", 32'(lvl2), 32'd0);
        chk("t1_nout", 32'(n_out), 32'd1);

        // 2: six pairs on consecutive cycles
        @(posedge clk); #1;
        idx = 0; cyc = 0;
        while (idx < 6 && cyc < 200) begin
            in_valid = 1'b1; in_a = ta[idx]; in_b = tb[idx];
            @(negedge clk);
            if (cyc == 4) chk("t2_ready_c4", 32'(in_ready), 32'd1);
            if (cyc == 5) chk("t2_ready_c5", 32'(in_ready), 32'd0);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        wait_nout(7, "t2_drain");
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: downstream backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_pair(8'd5, 8'd9);
        push_pair(8'd7, 8'd11);
        begin
            int t = 0;
            while (!out_valid && t < 60) begin @(negedge clk); t++; end
        end
        chk("t3_valid", 32'(out_valid), 32'd1);
        y0 = out_y; stable = 1'b1; nstart = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_y !== y0 || !out_valid) stable = 1'b0;
            if (m.start) nstart++;
        end
        chk("t3_y_value", 32'(y0), 32'd45);
        chk("t3_y_stable", 32'(stable), 32'd1);
        chk("t3_no_start", 32'(nstart), 32'd0);
        chk("t3_level", 32'(level), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_no_start_yet", 32'(m.start), 32'd0);
        @(negedge clk);
        chk("t3_start_after_accept", 32'(m.start), 32'd1);
        wait_nout(9, "t3_drain");

        // 4: busy never rises
        @(posedge clk); #1;
        dead = 1'b1;
        push_pair(8'd9, 8'd9);
        push_pair(8'd4, 8'd5);
        wait_start("t4_start");
        @(posedge clk); #1;
        dead = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("t4_err_before", 32'(err), 32'd0);
        @(negedge clk);
        chk("t4_err_set", 32'(err), 32'd1);
        if (sb.size() > 0) void'(sb.pop_front());
        wait_nout(10, "t4_next_product");
        chk("t4_err_sticky", 32'(err), 32'd1);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5: reset during WAIT_DONE with three pairs queued
        @(posedge clk); #1;
        push_pair(8'd1, 8'd2);
        push_pair(8'd3, 8'd4);
        push_pair(8'd5, 8'd6);
        push_pair(8'd7, 8'd8);
        begin
            int t = 0;
            while (!(m.busy && level == 3'd3) && t < 40) begin @(negedge clk); t++; end
        end
        chk("t5_queued", 32'(level), 32'd3);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_start", 32'(m.start), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        n_before = n_out; stable = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || m.start) stable = 1'b0;
        end
        chk("t5_no_stale", 32'(stable), 32'd1);
        chk("t5_nout", 32'(n_out), 32'(n_before));

        // 6: push into a full FIFO in the same cycle an issue pops
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_pair(8'd2, 8'd3);
        begin
            int t = 0;
            while (!out_valid && t < 60) begin @(negedge clk); t++; end
        end
        @(posedge clk); #1;
        push_pair(8'd10, 8'd10);
        push_pair(8'd11, 8'd11);
        push_pair(8'd12, 8'd12);
        push_pair(8'd13, 8'd13);
        in_valid = 1'b1; in_a = 8'd14; in_b = 8'd14;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_full_level", 32'(level), 32'(DEPTH));
        chk("t6_full_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t6_pop_level", 32'(level), 32'(DEPTH - 1));
        chk("t6_pop_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_refill_level", 32'(level), 32'(DEPTH));
        wait_nout(n_before + 6, "t6_drain");
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
